// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronizes the raw line, samples each bit at its centre,
// and emits a one-cycle strobe per frame (good byte or framing error).
module uart_rx_8n1 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iRXD,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oBUSY
);

  localparam int N  = CLK_FREQ / BAUD;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  // Synchronizer resets to the idle (high) level so reset never fakes a start bit.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= iRXD;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register updates
  // from pre-edge values, regardless of statement order within the block.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      oDATA      <= '0;
      oVALID     <= 1'b0;
      oFRAME_ERR <= 1'b0;
    end else begin
      oVALID     <= 1'b0;
      oFRAME_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= CW'(H - 1);
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            cnt     <= CW'(N - 1);
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= CW'(N - 1);
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            oDATA  <= shreg;
            oVALID <= 1'b1;
            state  <= IDLE;
          end else begin
            oFRAME_ERR <= 1'b1;
            state      <= WAIT_HIGH;
          end
        end
        // A held-low line (break) must go high before another frame is accepted.
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oBUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares whenever the receiver strobes.
module tb_uart_rx_8n1;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int N        = 10;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] model_data = 8'h00;
  int         busy_run = 0;
  int         last_busy_len = 0;
  int         last_valid_cyc = -1;
  int         valid_gap = 0;
  logic       prev_strobe = 1'b0;

  uart_rx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iRXD      (rxd),
    .oDATA     (o_data),
    .oVALID    (o_valid),
    .oFRAME_ERR(o_frame_err),
    .oBUSY     (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every strobe against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (o_busy) busy_run++;
    else begin
      if (busy_run != 0) last_busy_len = busy_run;
      busy_run = 0;
    end
    if (o_valid || o_frame_err) begin
      check("strobe_exclusive", 32'(o_valid & o_frame_err), 32'd0);
      check("strobe_single_cycle", 32'(prev_strobe), 32'd0);
      check("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_kind_err", 32'(o_frame_err), 32'(e.err));
        check("data", 32'(o_data), 32'(e.data));
      end
      if (o_valid) begin
        check("busy_low_at_valid", 32'(o_busy), 32'd0);
        if (last_valid_cyc >= 0) valid_gap = cyc - last_valid_cyc;
        last_valid_cyc = cyc;
      end
    end
    prev_strobe = o_valid || o_frame_err;
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference: a good frame yields its byte; a low stop bit yields an error
  // strobe while the output keeps the last good byte.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int low_extra);
    exp_t e;
    e.err = ~stop;
    if (stop) begin
      model_data = d;
      e.data     = d;
    end else begin
      e.data = model_data;
    end
    sb.push_back(e);
    rxd = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (N) @(negedge clk);
    end
    rxd = stop;
    repeat (N) @(negedge clk);
    if (!stop) repeat (low_extra) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    int k;
    k = 0;
    while (sb.size() != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(o_data), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(o_frame_err), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       bad;

    // Reset values
    rst = 1'b1;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    idle(5);

    // Single 0x55 frame; busy spans H + 9N cycles
    send_frame(8'h55, 1'b1, 0);
    idle(10);
    wait_drain(50);
    check("busy_len_0x55", 32'(last_busy_len), 32'd95);

    // Glitch: three low cycles form a false start
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_rises", 32'(o_busy), 32'd1);
    rxd = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy_back_low", 32'(o_busy), 32'd0);
    check("glitch_data_kept", 32'(o_data), 32'(model_data));

    // Back-to-back frames with no idle gap
    send_frame(8'hA3, 1'b1, 0);
    send_frame(8'h00, 1'b1, 0);
    idle(10);
    wait_drain(50);
    check("b2b_valid_gap", 32'(valid_gap), 32'd100);

    // Framing error with a held-low line, then recovery
    send_frame(8'hC7, 1'b1, 0);
    idle(5);
    send_frame(8'h3C, 1'b0, 50);
    check("break_busy_held", 32'(o_busy), 32'd1);
    idle(5);
    check("break_busy_released", 32'(o_busy), 32'd0);
    check("break_data_kept", 32'(o_data), 32'h0000_00C7);
    wait_drain(20);
    send_frame(8'h81, 1'b1, 0);
    idle(10);
    wait_drain(50);

    // Reset during data bit 4 of a 0xFF frame
    rxd = 1'b0;
    repeat (N) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * N + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_data = 8'h00;
    check_all_zero("midframe_reset");
    idle(45 + 20);
    send_frame(8'h12, 1'b1, 0);
    idle(10);
    wait_drain(50);

    // Randomized frames, gaps and occasional framing errors
    for (int i = 0; i < 30; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(d, ~bad, int'($urandom_range(0, 30)));
      if (bad) idle(int'($urandom_range(3, 15)));
      else     idle(int'($urandom_range(0, 15)));
    end
    idle(20);
    wait_drain(300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
